oc_harness_uart_host: RTL and testbench

- Synthesizable UART host stage that sits directly upstream of the chip harness UART pins.
- Takes a byte stream from the bench or sequencer and serializes it onto the harness `uartRx` input.
- Deserializes the harness `uartTx` output into a buffered byte stream.
- Tracks link errors in saturating counters, so directed tests drive the control UART through valid/ready streams instead of bit-level tasks.

---
 rtl/oc_harness_uart_host.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_oc_harness_uart_host.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oc_harness_uart_host.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | oc_harness_uart_host: byte-stream UART host for the chip harness pins,   |
// | TX serializer, RX deserializer + FIFO, saturating error counters.        |
// | Optional even parity: OC_HARNESS_UART_HOST_PARITY_EN                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module oc_harness_uart_host #(
  parameter int CLOCK_HZ      = 100_000_000,
  parameter int BAUD          = 10_000_000,
  parameter int RX_FIFO_DEPTH = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] inData,
  input  logic       inValid,
  output logic       inReady,
  output logic [7:0] outData,
  output logic       outValid,
  input  logic       outReady,
  output logic       uartTxOut,
  input  logic       uartRxIn,
  output logic       txBusy,
  output logic [7:0] frameErrors,
  output logic [7:0] overflows,
  output logic [7:0] parityErrors
);
  localparam int c_cyclesPerBit = CLOCK_HZ / BAUD;
  localparam int c_halfBit      = c_cyclesPerBit / 2;
  localparam int c_cntW         = $clog2(c_cyclesPerBit + 1);
  localparam int c_ptrW         = $clog2(RX_FIFO_DEPTH);

  generate
    if (c_cyclesPerBit < 4) begin : g_badBaud
      $error("oc_harness_uart_host: CLOCK_HZ/BAUD must be at least 4");
    end
    if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_badDepth
      $error("oc_harness_uart_host: RX_FIFO_DEPTH must be a power of two >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_badSync
      $error("oc_harness_uart_host: SYNC_STAGES must be >= 2");
    end
  endgenerate

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_t;
  txState_t          r_txState, w_txStateNext;
  logic [c_cntW-1:0] r_txCnt, w_txCntNext;
  logic [2:0]        r_txBit, w_txBitNext;
  logic [7:0]        r_txShift, w_txShiftNext;
  logic              r_txLine, w_txLineNext;
  logic              w_txBitDone;

  assign w_txBitDone = (r_txCnt == c_cntW'(c_cyclesPerBit - 1));
  assign inReady     = (r_txState == TX_IDLE) && !reset;
  assign txBusy      = !inReady;
  assign uartTxOut   = r_txLine;

`ifdef OC_HARNESS_UART_HOST_PARITY_EN
  logic r_txParity;
  always_ff @(posedge clock) begin
    if (reset)                               r_txParity <= 1'b0;
    else if (r_txState == TX_IDLE && inValid) r_txParity <= ^inData;
  end
`endif

  always_comb begin
    w_txStateNext = r_txState;
    w_txCntNext   = r_txCnt + 1'b1;
    w_txBitNext   = r_txBit;
    w_txShiftNext = r_txShift;
    w_txLineNext  = r_txLine;
    unique case (r_txState)
      TX_IDLE: begin
        w_txCntNext  = '0;
        w_txLineNext = 1'b1;
        if (inValid) begin
          w_txStateNext = TX_START;
          w_txShiftNext = inData;
          w_txLineNext  = 1'b0;
        end
      end
      TX_START: if (w_txBitDone) begin
        w_txCntNext   = '0;
        w_txStateNext = TX_DATA;
        w_txBitNext   = '0;
        w_txLineNext  = r_txShift[0];
      end
      TX_DATA: if (w_txBitDone) begin
        w_txCntNext = '0;
        if (r_txBit == 3'd7) begin
`ifdef OC_HARNESS_UART_HOST_PARITY_EN
          w_txStateNext = TX_PARITY;
          w_txLineNext  = r_txParity;
`else
          w_txStateNext = TX_STOP;
          w_txLineNext  = 1'b1;
`endif
        end else begin
          w_txBitNext   = r_txBit + 3'd1;
          w_txShiftNext = r_txShift >> 1;
          w_txLineNext  = r_txShift[1];
        end
      end
      TX_PARITY: if (w_txBitDone) begin
        w_txCntNext   = '0;
        w_txStateNext = TX_STOP;
        w_txLineNext  = 1'b1;
      end
      TX_STOP: if (w_txBitDone) begin
        w_txCntNext   = '0;
        w_txStateNext = TX_IDLE;
      end
      default: w_txStateNext = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_txState <= TX_IDLE;
      r_txCnt   <= '0;
      r_txBit   <= '0;
      r_txShift <= '0;
      r_txLine  <= 1'b1;
    end else begin
      r_txState <= w_txStateNext;
      r_txCnt   <= w_txCntNext;
      r_txBit   <= w_txBitNext;
      r_txShift <= w_txShiftNext;
      r_txLine  <= w_txLineNext;
    end
  end

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rxState_t;
  rxState_t           r_rxState, w_rxStateNext;
  logic [c_cntW-1:0]  r_rxCnt, w_rxCntNext;
  logic [2:0]         r_rxBit, w_rxBitNext;
  logic [7:0]         r_rxShift, w_rxShiftNext;
  logic [SYNC_STAGES-1:0] r_sync;
  logic               r_rxPrev, w_rxIn, w_rxSample, w_rxParErr;
  logic               w_rxPush, w_frameInc;

  assign w_rxIn     = r_sync[SYNC_STAGES-1];
  // Counter is reloaded to 1 so the sample lands exactly on the target count.
  assign w_rxSample = (r_rxCnt == ((r_rxState == RX_START) ? c_cntW'(c_halfBit)
                                                            : c_cntW'(c_cyclesPerBit)));

  always_comb begin
    w_rxStateNext = r_rxState;
    w_rxCntNext   = r_rxCnt + 1'b1;
    w_rxBitNext   = r_rxBit;
    w_rxShiftNext = r_rxShift;
    w_rxPush      = 1'b0;
    w_frameInc    = 1'b0;
    unique case (r_rxState)
      RX_IDLE: begin
        w_rxCntNext = c_cntW'(1);
        if (r_rxPrev && !w_rxIn) w_rxStateNext = RX_START;
      end
      RX_START: if (w_rxSample) begin
        w_rxCntNext   = c_cntW'(1);
        w_rxBitNext   = '0;
        w_rxStateNext = w_rxIn ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (w_rxSample) begin
        w_rxCntNext   = c_cntW'(1);
        w_rxShiftNext = {w_rxIn, r_rxShift[7:1]};
        w_rxBitNext   = r_rxBit + 3'd1;
        if (r_rxBit == 3'd7) begin
`ifdef OC_HARNESS_UART_HOST_PARITY_EN
          w_rxStateNext = RX_PARITY;
`else
          w_rxStateNext = RX_STOP;
`endif
        end
      end
      RX_PARITY: if (w_rxSample) begin
        w_rxCntNext   = c_cntW'(1);
        w_rxStateNext = RX_STOP;
      end
      RX_STOP: if (w_rxSample) begin
        if (!w_rxIn) begin
          w_frameInc    = 1'b1;
          w_rxStateNext = RX_WAIT_HIGH;
        end else begin
          w_rxPush      = !w_rxParErr;
          w_rxStateNext = RX_IDLE;
        end
      end
      RX_WAIT_HIGH: begin
        w_rxCntNext = c_cntW'(1);
        if (w_rxIn) w_rxStateNext = RX_IDLE;
      end
      default: w_rxStateNext = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync    <= '1;
      r_rxPrev  <= 1'b1;
      r_rxState <= RX_IDLE;
      r_rxCnt   <= '0;
      r_rxBit   <= '0;
      r_rxShift <= '0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], uartRxIn};
      r_rxPrev  <= w_rxIn;
      r_rxState <= w_rxStateNext;
      r_rxCnt   <= w_rxCntNext;
      r_rxBit   <= w_rxBitNext;
      r_rxShift <= w_rxShiftNext;
    end
  end

`ifdef OC_HARNESS_UART_HOST_PARITY_EN
  logic       r_rxParErr;
  logic [7:0] r_parityErrors;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rxParErr     <= 1'b0;
      r_parityErrors <= '0;
    end else begin
      if (r_rxState == RX_PARITY && w_rxSample) r_rxParErr <= w_rxIn ^ (^r_rxShift);
      if (r_rxState == RX_STOP && w_rxSample && r_rxParErr && r_parityErrors != 8'hFF)
        r_parityErrors <= r_parityErrors + 8'd1;
    end
  end
  assign w_rxParErr   = r_rxParErr;
  assign parityErrors = r_parityErrors;
`else
  assign w_rxParErr   = 1'b0;
  assign parityErrors = '0;
`endif

  // -------------------------------------------------------------- FIFO
  logic [7:0]        r_mem [RX_FIFO_DEPTH];
  logic [c_ptrW-1:0] r_wrPtr, r_rdPtr, w_rdPtrNext;
  logic [c_ptrW:0]   r_count, w_countAfterPop;
  logic [7:0]        r_outData, w_headNext, r_frameErrors, r_overflows;
  logic              w_pop, w_pushOk, w_overflow;

  assign outValid    = (r_count != '0);
  assign outData     = r_outData;
  assign frameErrors = r_frameErrors;
  assign overflows   = r_overflows;

  // Pop is applied before push, so a full FIFO can pop and accept in one cycle.
  always_comb begin
    w_pop           = outValid && outReady;
    w_countAfterPop = r_count - (c_ptrW + 1)'(w_pop);
    w_pushOk        = w_rxPush && (w_countAfterPop != (c_ptrW + 1)'(RX_FIFO_DEPTH));
    w_overflow      = w_rxPush && !w_pushOk;
    w_rdPtrNext     = r_rdPtr + c_ptrW'(w_pop);
    if (w_countAfterPop == '0) w_headNext = w_pushOk ? r_rxShift : r_outData;
    else                       w_headNext = r_mem[w_rdPtrNext];
  end

  always_ff @(posedge clock) begin
    if (w_pushOk) r_mem[r_wrPtr] <= r_rxShift;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_count       <= '0;
      r_outData     <= '0;
      r_frameErrors <= '0;
      r_overflows   <= '0;
    end else begin
      r_wrPtr   <= r_wrPtr + c_ptrW'(w_pushOk);
      r_rdPtr   <= w_rdPtrNext;
      r_count   <= w_countAfterPop + (c_ptrW + 1)'(w_pushOk);
      r_outData <= w_headNext;
      if (w_frameInc && r_frameErrors != 8'hFF) r_frameErrors <= r_frameErrors + 8'd1;
      if (w_overflow && r_overflows != 8'hFF)   r_overflows   <= r_overflows + 8'd1;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_oc_harness_uart_host.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_oc_harness_uart_host: randomized self-checking bench for the UART     |
// | host against a frame-level reference model.                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_oc_harness_uart_host;
  localparam int CPB = 10;
`ifdef OC_HARNESS_UART_HOST_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam bit PAR_EN     = 1'b1;
`else
  localparam int FRAME_BITS = 10;
  localparam bit PAR_EN     = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] inData = '0;
  logic       inValid = 1'b0;
  logic       outReady = 1'b0;
  logic       loopback = 1'b0;
  logic       drvLine = 1'b1;
  logic       inReady, outValid, uartTxOut, txBusy, rxLine;
  logic [7:0] outData, frameErrors, overflows, parityErrors;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] gotQ[$];
  int validCycles = 0;

  assign rxLine = loopback ? uartTxOut : drvLine;

  oc_harness_uart_host #(
    .CLOCK_HZ(100_000_000), .BAUD(10_000_000), .RX_FIFO_DEPTH(4), .SYNC_STAGES(2)
  ) dut (
    .clock(clock), .reset(reset),
    .inData(inData), .inValid(inValid), .inReady(inReady),
    .outData(outData), .outValid(outValid), .outReady(outReady),
    .uartTxOut(uartTxOut), .uartRxIn(rxLine), .txBusy(txBusy),
    .frameErrors(frameErrors), .overflows(overflows), .parityErrors(parityErrors)
  );

  always #5 clock = ~clock;

  // Sole writer of the receive log; tasks only read it.
  always @(negedge clock) begin
    if (outValid) validCycles++;
    if (outValid && outReady) gotQ.push_back(outData);
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Line levels of one frame, index 0 = start bit.
  function automatic logic [10:0] frameBits(input logic [7:0] b);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    if (PAR_EN) f[9] = ^b;
    return f;
  endfunction

  task automatic doReset();
    inValid = 1'b0; outReady = 1'b0; loopback = 1'b0; drvLine = 1'b1;
    @(negedge clock); reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clock);
    while (!inReady && n < 3000) begin @(negedge clock); n++; end
    if (!inReady) begin
      miscompares++;
      $display("FAIL send_timeout: inReady=%b required 1", inReady);
      return;
    end
    inData = b; inValid = 1'b1;
    @(posedge clock); #1 inValid = 1'b0;
  endtask

  task automatic waitRx(input int target);
    for (int i = 0; i < 6000 && gotQ.size() < target; i++) @(negedge clock);
  endtask

  task automatic driveFrame(input logic [7:0] b, input logic stopBit, input logic flipPar);
    logic [10:0] f;
    f = frameBits(b);
    if (PAR_EN && flipPar) f[9] = ~f[9];
    f[FRAME_BITS-1] = stopBit;
    @(posedge clock); #1;
    for (int i = 0; i < FRAME_BITS; i++) begin
      drvLine = f[i];
      repeat (CPB) @(posedge clock);
      #1;
    end
    drvLine = 1'b1;
    repeat (2 * CPB) @(posedge clock);
  endtask

  task automatic test_reset();
    doReset();
    @(negedge clock);
    vectors++;
    if ({uartTxOut, inReady, txBusy, outValid} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_ctrl: tx/inReady/busy/valid=%b required 1100",
               {uartTxOut, inReady, txBusy, outValid});
    end
    vectors++;
    if ({outData, frameErrors, overflows, parityErrors} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_regs: data/fe/ov/pe=%h required 00000000",
               {outData, frameErrors, overflows, parityErrors});
    end
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if (inReady !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_inready: inReady=%b during reset required 0", inReady);
    end
    @(posedge clock); #1 reset = 1'b0;
  endtask

  task automatic test_tx_frame(input logic [7:0] b);
    logic [10:0] f;
    int bad;
    f = frameBits(b);
    loopback = 1'b0;
    send(b);
    bad = 0;
    for (int k = 0; k < FRAME_BITS * CPB; k++) begin
      @(negedge clock);
      vectors++;
      if (uartTxOut !== f[k / CPB] || inReady !== 1'b0 || txBusy !== 1'b1) begin
        miscompares++;
        if (bad++ < 4)
          $display("FAIL tx_line byte=%h cycle=%0d: line=%b ready=%b busy=%b required %b 0 1",
                   b, k + 1, uartTxOut, inReady, txBusy, f[k / CPB]);
      end
    end
    @(negedge clock);
    vectors++;
    if (inReady !== 1'b1 || uartTxOut !== 1'b1) begin
      miscompares++;
      $display("FAIL tx_ready_return byte=%h: inReady=%b line=%b required 1 1", b, inReady, uartTxOut);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] exp[$];
    int base;
    doReset();
    loopback = 1'b1; outReady = 1'b1;
    exp = '{8'h00, 8'hFF, 8'h55, 8'h80};
    for (int i = 0; i < 6; i++) exp.push_back(8'($urandom_range(0, 255)));
    base = gotQ.size();
    foreach (exp[i]) send(exp[i]);
    waitRx(base + exp.size());
    vectors++;
    if (gotQ.size() != base + exp.size()) begin
      miscompares++;
      $display("FAIL loopback_count: got %0d bytes required %0d", gotQ.size() - base, exp.size());
    end
    foreach (exp[i]) begin
      if (base + i < gotQ.size()) begin
        vectors++;
        if (gotQ[base + i] !== exp[i]) begin
          miscompares++;
          $display("FAIL loopback_byte%0d: got %h required %h", i, gotQ[base + i], exp[i]);
        end
      end
    end
    vectors++;
    if ({frameErrors, overflows, parityErrors} !== 24'h0) begin
      miscompares++;
      $display("FAIL loopback_counters: %h required 000000", {frameErrors, overflows, parityErrors});
    end
  endtask

  task automatic test_frame_error();
    logic [7:0] exp[$];
    int base, vc, expFe, expPe;
    logic [7:0] b;
    logic stopOk, flip;
    doReset();
    outReady = 1'b1;
    vc = validCycles;
    driveFrame(8'h3C, 1'b0, 1'b0);
    vectors++;
    if (frameErrors !== 8'd1 || validCycles != vc) begin
      miscompares++;
      $display("FAIL frame_err: frameErrors=%0d validCycles=%0d required 1 0", frameErrors, validCycles - vc);
    end
    base = gotQ.size();
    driveFrame(8'h12, 1'b1, 1'b0);
    vectors++;
    if (gotQ.size() != base + 1 || gotQ[gotQ.size() - 1] !== 8'h12) begin
      miscompares++;
      $display("FAIL frame_recover: got %0d bytes last=%h required 1 byte 12",
               gotQ.size() - base, gotQ.size() > 0 ? gotQ[gotQ.size() - 1] : 8'hxx);
    end
    expFe = 1; expPe = 0;
    base = gotQ.size();
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      stopOk = ($urandom_range(0, 3) != 0);
      flip = PAR_EN && ($urandom_range(0, 3) == 0);
      driveFrame(b, stopOk, flip);
      if (!stopOk) expFe++;
      if (flip) expPe++;
      if (stopOk && !flip) exp.push_back(b);
    end
    vectors++;
    if (frameErrors !== 8'(expFe) || parityErrors !== 8'(expPe)) begin
      miscompares++;
      $display("FAIL frame_random_counters: fe=%0d pe=%0d required %0d %0d", frameErrors, parityErrors, expFe, expPe);
    end
    vectors++;
    if (gotQ.size() != base + exp.size()) begin
      miscompares++;
      $display("FAIL frame_random_count: got %0d required %0d", gotQ.size() - base, exp.size());
    end else begin
      foreach (exp[i]) begin
        vectors++;
        if (gotQ[base + i] !== exp[i]) begin
          miscompares++;
          $display("FAIL frame_random_byte%0d: got %h required %h", i, gotQ[base + i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int base;
    doReset();
    loopback = 1'b1; outReady = 1'b0;
    for (int i = 1; i <= 6; i++) send(8'(i));
    repeat (200) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (outValid !== 1'b1 || outData !== 8'h01 || overflows !== 8'd2) begin
      miscompares++;
      $display("FAIL overflow_state: valid=%b head=%h overflows=%0d required 1 01 2", outValid, outData, overflows);
    end
    base = gotQ.size();
    outReady = 1'b1;
    repeat (10) @(negedge clock);
    vectors++;
    if (gotQ.size() != base + 4 || outValid !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_drain_count: got %0d valid=%b required 4 0", gotQ.size() - base, outValid);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (gotQ[base + i] !== 8'(i + 1)) begin
          miscompares++;
          $display("FAIL overflow_drain%0d: got %h required %h", i, gotQ[base + i], 8'(i + 1));
        end
      end
    end
  endtask

  task automatic test_glitch();
    int vc, base;
    doReset();
    outReady = 1'b1;
    vc = validCycles;
    @(posedge clock); #1 drvLine = 1'b0;
    repeat (3) @(posedge clock);
    #1 drvLine = 1'b1;
    repeat (300) @(posedge clock);
    vectors++;
    if (validCycles != vc || {frameErrors, overflows, parityErrors} !== 24'h0) begin
      miscompares++;
      $display("FAIL glitch: validCycles=%0d counters=%h required 0 000000",
               validCycles - vc, {frameErrors, overflows, parityErrors});
    end
    base = gotQ.size();
    driveFrame(8'h5A, 1'b1, 1'b0);
    vectors++;
    if (gotQ.size() != base + 1 || gotQ[gotQ.size() - 1] !== 8'h5A) begin
      miscompares++;
      $display("FAIL glitch_recover: got %0d bytes required 1 byte 5a", gotQ.size() - base);
    end
  endtask

  task automatic test_reset_midframe();
    doReset();
    send(8'($urandom_range(0, 255)));
    repeat (44) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (txBusy !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe_busy: txBusy=%b required 1", txBusy);
    end
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (uartTxOut !== 1'b1 || inReady !== 1'b1 || txBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_reset: line=%b inReady=%b busy=%b required 1 1 0", uartTxOut, inReady, txBusy);
    end
    test_tx_frame(8'($urandom_range(0, 255)));
  endtask

`ifdef OC_HARNESS_UART_HOST_PARITY_EN
  task automatic test_parity();
    int vc;
    doReset();
    test_tx_frame(8'h07);
    outReady = 1'b1;
    vc = validCycles;
    driveFrame(8'h5A, 1'b1, 1'b1);
    vectors++;
    if (parityErrors !== 8'd1 || validCycles != vc || frameErrors !== 8'd0) begin
      miscompares++;
      $display("FAIL parity_inject: pe=%0d validCycles=%0d fe=%0d required 1 0 0",
               parityErrors, validCycles - vc, frameErrors);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_tx_frame(8'hA5);
    for (int i = 0; i < 3; i++) test_tx_frame(8'($urandom_range(0, 255)));
    test_loopback();
    test_frame_error();
    test_overflow();
    test_glitch();
    test_reset_midframe();
`ifdef OC_HARNESS_UART_HOST_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
